// File: rtl/sound_sequencer.sv
// Sound-effect sequencer: plays fixed note lists as frequency targets
// for a tone generator, with request priority, preemption and mute.
module sound_sequencer #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int TICK_DIV = CLK_FREQ / 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [9:0] target_freq,
  output logic       busy,
  output logic [1:0] cur_id,
  output logic       done
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {
    IDLE,
    PLAY
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    id_q, id_d;
  logic [2:0]    idx_q, idx_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    ms_q, ms_d;
  logic [9:0]    freq_q, freq_d;
  logic [9:0]    tgt_q, tgt_d;
  logic          done_q, done_d;

  logic          win_vld;
  logic [1:0]    win_id;
  logic          accept;
  logic          tick;
  logic          expire;
  logic [2:0]    idx_nx;
  logic [17:0]   nxt;
  logic [17:0]   first;

  // {freq, dur_ms}; a zero duration terminates the sound
  function automatic logic [17:0] note(
    input logic [1:0] id,
    input logic [2:0] idx
  );
    logic [17:0] n;
    n = '0;
    case ({id, idx})
      5'b00_000: n = {10'd523, 8'd150};
      5'b00_001: n = {10'd659, 8'd150};
      5'b00_010: n = {10'd784, 8'd150};
      5'b01_000: n = {10'd300, 8'd30};
      5'b01_001: n = {10'd200, 8'd30};
      5'b10_000: n = {10'd880, 8'd50};
      5'b10_001: n = {10'd0,   8'd20};
      5'b10_010: n = {10'd880, 8'd50};
      5'b11_000: n = {10'd784, 8'd120};
      5'b11_001: n = {10'd698, 8'd120};
      5'b11_010: n = {10'd622, 8'd120};
      5'b11_011: n = {10'd523, 8'd240};
      default:   n = '0;
    endcase
    return n;
  endfunction

  // larger rank wins: death > start > ghost > chomp
  function automatic logic [1:0] rank(input logic [1:0] id);
    logic [1:0] r;
    case (id)
      2'd3:    r = 2'd3;
      2'd0:    r = 2'd2;
      2'd2:    r = 2'd1;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // pick the highest-priority request this cycle
  always_comb begin
    win_vld = |req;
    win_id  = 2'd0;
    if (req[3])      win_id = 2'd3;
    else if (req[0]) win_id = 2'd0;
    else if (req[2]) win_id = 2'd2;
    else if (req[1]) win_id = 2'd1;
  end

  assign accept = win_vld &&
                  ((state_q == IDLE) || (rank(win_id) >= rank(id_q)));
  assign tick   = (pre_q == PRE_MAX);
  assign expire = tick && (ms_q == 8'd1);
  assign idx_nx = idx_q + 3'd1;
  assign nxt    = note(id_q, idx_nx);
  assign first  = note(win_id, 3'd0);

  // next state: accept, advance timing, step notes, finish
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    idx_d   = idx_q;
    pre_d   = pre_q;
    ms_d    = ms_q;
    freq_d  = freq_q;
    done_d  = 1'b0;
    if (accept) begin
      state_d = PLAY;
      id_d    = win_id;
      idx_d   = 3'd0;
      pre_d   = '0;
      ms_d    = first[7:0];
      freq_d  = first[17:8];
    end else if (state_q == PLAY) begin
      pre_d = tick ? '0 : pre_q + PW'(1);
      if (tick) ms_d = ms_q - 8'd1;
      if (expire) begin
        if (nxt[7:0] == 8'd0) begin
          state_d = IDLE;
          id_d    = 2'd0;
          idx_d   = 3'd0;
          pre_d   = '0;
          ms_d    = 8'd0;
          freq_d  = 10'd0;
          done_d  = 1'b1;
        end else begin
          idx_d  = idx_nx;
          ms_d   = nxt[7:0];
          freq_d = nxt[17:8];
        end
      end
    end
    tgt_d = mute ? 10'd0 : freq_d;
  end

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      idx_q   <= 3'd0;
      pre_q   <= '0;
      ms_q    <= 8'd0;
      freq_q  <= 10'd0;
      tgt_q   <= 10'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      ms_q    <= ms_d;
      freq_q  <= freq_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  assign target_freq = tgt_q;
  assign busy        = (state_q == PLAY);
  assign cur_id      = id_q;
  assign done        = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random traffic,
// each cycle compared against a time-based reference of the sounds.
module tb_sound_sequencer;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'd0;
  logic       mute = 1'b0;
  logic [9:0] target_freq;
  logic       busy;
  logic [1:0] cur_id;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  int fr[4][4] = '{'{523, 659, 784, 0}, '{300, 200, 0, 0},
                   '{880, 0, 880, 0},   '{784, 698, 622, 523}};
  int du[4][4] = '{'{150, 150, 150, 0}, '{30, 30, 0, 0},
                   '{50, 20, 50, 0},    '{120, 120, 120, 240}};
  int ord[4]   = '{3, 0, 2, 1};

  bit m_play;
  int m_id;
  int m_t;
  bit m_done;
  int exp_freq;

  sound_sequencer #(.CLK_FREQ(4000), .TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .req(req), .mute(mute),
    .target_freq(target_freq), .busy(busy),
    .cur_id(cur_id), .done(done)
  );

  always #5 clk = ~clk;

  function automatic int total(input int id);
    int s = 0;
    for (int i = 0; i < 4; i++) s += du[id][i] * TD;
    return s;
  endfunction

  function automatic int freq_at(input int id, input int t);
    int acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (du[id][i] == 0) return 0;
      if (t < acc + du[id][i] * TD) return fr[id][i];
      acc += du[id][i] * TD;
    end
    return 0;
  endfunction

  function automatic int pos_of(input int id);
    for (int i = 0; i < 4; i++) if (ord[i] == id) return i;
    return 4;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic m,
                            input logic rs);
    int w = -1;
    for (int i = 0; i < 4; i++)
      if (w < 0 && r[ord[i]]) w = ord[i];
    m_done = 0;
    if (rs) begin
      m_play = 0; m_id = 0; m_t = 0;
    end else if (w >= 0 && (!m_play || pos_of(w) <= pos_of(m_id))) begin
      m_play = 1; m_id = w; m_t = 0;
    end else if (m_play) begin
      m_t++;
      if (m_t >= total(m_id)) begin
        m_play = 0; m_id = 0; m_t = 0; m_done = 1;
      end
    end
    exp_freq = (rs || m || !m_play) ? 0 : freq_at(m_id, m_t);
  endtask

  function automatic logic [13:0] dut_vec();
    return {target_freq, busy, cur_id, done};
  endfunction

  function automatic logic [13:0] exp_vec();
    return {10'(exp_freq), m_play, 2'(m_id), m_done};
  endfunction

  task automatic step(input logic [3:0] r, input logic m,
                      input logic rs);
    req = r; mute = m; reset = rs;
    @(posedge clk);
    model_edge(r, m, rs);
    #1;
    req = 4'd0; reset = 1'b0;
  endtask

  task automatic test_reset();
    step(4'b1000, 0, 1);
    n_vec++;
    if (dut_vec() !== 14'd0) begin
      n_err++;
      $display("FAIL reset_req got %h want 0", dut_vec());
    end
    step(4'b0001, 1, 1);
    n_vec++;
    if (dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL reset_hold got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_chomp();
    step(4'b0010, 0, 0);
    n_vec++;
    if ({target_freq, busy, cur_id} !== {10'd300, 1'b1, 2'd1}) begin
      n_err++;
      $display("FAIL chomp_start got %0d/%b/%0d want 300/1/1",
               target_freq, busy, cur_id);
    end
    for (int i = 1; i <= 240; i++) begin
      step(4'd0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL chomp_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
      if (i == 120) begin
        n_vec++;
        if (target_freq !== 10'd200) begin
          n_err++;
          $display("FAIL chomp_note2 got %0d want 200", target_freq);
        end
      end
      if (i == 240) begin
        n_vec++;
        if ({target_freq, busy, done} !== {10'd0, 1'b0, 1'b1}) begin
          n_err++;
          $display("FAIL chomp_end got %0d/%b/%b want 0/0/1",
                   target_freq, busy, done);
        end
      end
    end
    step(4'd0, 0, 0);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL chomp_done_len got %b want 0", done);
    end
  endtask

  task automatic test_preempt();
    int cnt = 0;
    bit seen = 0;
    step(4'b0010, 0, 0);
    for (int i = 0; i < 50; i++) step(4'd0, 0, 0);
    step(4'b1000, 0, 0);
    n_vec++;
    if ({target_freq, cur_id, done} !== {10'd784, 2'd3, 1'b0}) begin
      n_err++;
      $display("FAIL preempt_start got %0d/%0d/%b want 784/3/0",
               target_freq, cur_id, done);
    end
    for (int i = 0; i < 3000 && !seen; i++) begin
      step(4'd0, 0, 0);
      cnt++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL preempt_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
      if (done) seen = 1;
    end
    n_vec++;
    if (!seen || cnt != 2400) begin
      n_err++;
      $display("FAIL death_len got %0d cycles (done=%0d) want 2400",
               cnt, seen);
    end
  endtask

  task automatic test_death_restart();
    int cnt = 0;
    step(4'b1000, 0, 0);
    for (int i = 0; i < 100; i++) step(4'd0, 0, 0);
    step(4'b0001, 0, 0);
    n_vec++;
    if ({target_freq, cur_id} !== {10'd784, 2'd3} ||
        dut_vec() !== exp_vec()) begin
      n_err++;
      $display("FAIL start_ignored got %h want %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 368; i++) begin
      step(4'd0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL death_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    step(4'b1000, 0, 0);
    while (target_freq === 10'd784 && cnt < 600) begin
      step(4'd0, 0, 0);
      cnt++;
    end
    n_vec++;
    if (cnt != 480 || target_freq !== 10'd698) begin
      n_err++;
      $display("FAIL restart_note got %0d cycles/%0d want 480/698",
               cnt, target_freq);
    end
    for (int i = 0; i < 2500 && busy; i++) begin
      step(4'd0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL restart_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_ghost_rest();
    int rest = 0;
    step(4'b0110, 0, 0);
    n_vec++;
    if ({target_freq, cur_id} !== {10'd880, 2'd2}) begin
      n_err++;
      $display("FAIL ghost_wins got %0d/%0d want 880/2",
               target_freq, cur_id);
    end
    for (int i = 0; i < 1000 && busy; i++) begin
      step(4'd0, 0, 0);
      if (busy && target_freq === 10'd0) rest++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ghost_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    n_vec++;
    if (rest != 80) begin
      n_err++;
      $display("FAIL ghost_rest got %0d cycles want 80", rest);
    end
  endtask

  task automatic test_mute();
    int cnt = 0;
    bit seen = 0;
    step(4'b0001, 0, 0);
    for (int i = 0; i < 50; i++) begin step(4'd0, 0, 0); cnt++; end
    step(4'd0, 1, 0);
    cnt++;
    n_vec++;
    if ({target_freq, busy} !== {10'd0, 1'b1}) begin
      n_err++;
      $display("FAIL mute_on got %0d/%b want 0/1", target_freq, busy);
    end
    for (int i = 0; i < 29; i++) begin
      step(4'd0, 1, 0);
      cnt++;
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL mute_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
    step(4'd0, 0, 0);
    cnt++;
    n_vec++;
    if (target_freq !== 10'd523) begin
      n_err++;
      $display("FAIL mute_off got %0d want 523", target_freq);
    end
    for (int i = 0; i < 2000 && !seen; i++) begin
      step(4'd0, 0, 0);
      cnt++;
      if (done) seen = 1;
    end
    n_vec++;
    if (!seen || cnt != 1800) begin
      n_err++;
      $display("FAIL mute_len got %0d cycles (done=%0d) want 1800",
               cnt, seen);
    end
  endtask

  task automatic test_reset_mid();
    step(4'b0001, 0, 0);
    for (int i = 0; i < 100; i++) step(4'd0, 0, 0);
    step(4'd0, 0, 1);
    n_vec++;
    if (dut_vec() !== 14'd0) begin
      n_err++;
      $display("FAIL reset_mid got %h want 0", dut_vec());
    end
    for (int i = 0; i < 5; i++) begin
      step(4'd0, 0, 0);
      n_vec++;
      if (dut_vec() !== 14'd0) begin
        n_err++;
        $display("FAIL reset_quiet i=%0d got %h want 0", i, dut_vec());
      end
    end
    step(4'b0001, 0, 0);
    n_vec++;
    if ({target_freq, busy, cur_id} !== {10'd523, 1'b1, 2'd0}) begin
      n_err++;
      $display("FAIL reset_replay got %0d/%b/%0d want 523/1/0",
               target_freq, busy, cur_id);
    end
  endtask

  task automatic test_back_to_back();
    step(4'd0, 0, 1);
    step(4'b0010, 0, 0);
    for (int i = 0; i < 239; i++) step(4'd0, 0, 0);
    step(4'b0010, 0, 0);
    n_vec++;
    if ({target_freq, busy, cur_id, done} !==
        {10'd300, 1'b1, 2'd1, 1'b0}) begin
      n_err++;
      $display("FAIL b2b_restart got %h want %h",
               dut_vec(), {10'd300, 1'b1, 2'd1, 1'b0});
    end
    for (int i = 0; i < 300; i++) begin
      step(4'd0, 0, 0);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL b2b_trace i=%0d got %h want %h",
                 i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic       m = 1'b0;
    logic       rs;
    for (int i = 0; i < 4000; i++) begin
      r  = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      if ($urandom_range(0, 49) == 0) m = ~m;
      rs = ($urandom_range(0, 799) == 0);
      step(r, m, rs);
      n_vec++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random i=%0d req=%b got %h want %h",
                 i, r, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_chomp();
    test_preempt();
    test_death_restart();
    test_ghost_rest();
    test_mute();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
